key_event_ctrl: RTL
===================

// Module: key_event_ctrl
// PURPOSE
//  Multi-key debounce and event scheduler built around one shared sample-tick prescaler.
//  Per-key FSMs sample a synchronized switch only on the shared tick and emit level and
//  press/release/long/repeat pulses. Sits between board push-buttons and UI/mode logic
//  (e.g. SVGA mode select), replacing one wide debounce timer per key.
// PARAMETERS
//  NUM_KEYS   4      number of keys (>=1)
//  TICK_DIV   50000  clk cycles per sample tick (1 ms @ 50 MHz), >=2
//  DB_MS      20     consecutive equal samples needed to accept a change, >=1
//  LONG_MS    1000   samples held after press before long_tick, >DB_MS
//  REPEAT_MS  200    samples between repeat_tick pulses in long-hold, >=1
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         asynchronous active-low reset
//  sw            in   NUM_KEYS  raw switch inputs, asynchronous, 1 = pressed
//  repeat_en     in   1         1 = emit repeat_tick during long-hold
//  db_level      out  NUM_KEYS  debounced key level
//  press_tick    out  NUM_KEYS  1-clk pulse on accepted press
//  release_tick  out  NUM_KEYS  1-clk pulse on accepted release
//  long_tick     out  NUM_KEYS  1-clk pulse when hold reaches LONG_MS
//  repeat_tick   out  NUM_KEYS  1-clk pulse every REPEAT_MS in long-hold
// BEHAVIOUR
//  - Reset: all outputs 0, prescaler 0, every key FSM IDLE, counters 0, sync FFs 0.
//  - sw passes a 2-FF synchronizer per bit (2-clk latency); FSMs see only synced sw.
//  - Prescaler counts 0..TICK_DIV-1, wraps. smp_tick=1 for one clk when count==TICK_DIV-1.
//  - FSMs and per-key counters change only on smp_tick cycles. All outputs registered;
//    pulses are high in the clk after the deciding tick, for exactly one clk.
//  - Per-key FSM. s = synced sw, cnt = per-key sample counter (width clog2(LONG_MS+1)):
//    IDLE:   s=1 -> DEB_DN, cnt=1 (DB_MS==1: straight to HELD, press_tick).
//    DEB_DN: s=0 -> IDLE. s=1: cnt+1; cnt+1==DB_MS -> HELD, cnt=0, press_tick.
//    HELD:   s=0 -> DEB_UP, cnt=1, lng=0. s=1: cnt+1; ==LONG_MS -> LONG, cnt=0, long_tick.
//    LONG:   s=0 -> DEB_UP, cnt=1, lng=1. s=1: cnt+1; ==REPEAT_MS -> cnt=0,
//            repeat_tick if repeat_en.
//    DEB_UP: s=1 -> back to LONG if lng else HELD, cnt=0 (hold timer restarts).
//            s=0: cnt+1; ==DB_MS -> IDLE, cnt=0, release_tick.
//  - db_level=1 in HELD, LONG, DEB_UP; 0 in IDLE, DEB_DN.
//  - Keys are independent: simultaneous events on several keys pulse together; no priority.
//  - repeat_en low: LONG counter still wraps, repeat_tick suppressed; no catch-up pulse.
//  - Reset asserted mid-operation: immediate return to reset state; a key still held
//    after reset release is re-debounced from IDLE (press_tick after DB_MS samples).
//  - Max press latency: 2 + DB_MS*TICK_DIV + 1 clk from sw edge.
// STRUCTURE
//  - Shared header key_event_defs.vh: FSM state encodings (IDLE, DEB_DN, HELD, LONG,
//    DEB_UP, 3 bits) and a clog2 function.
//  - Top: synchronizers, shared prescaler, generate loop of NUM_KEYS sub-modules.
//  - Sub-module key_event_fsm: one key; inputs clk, rst_n, smp_tick, s, repeat_en;
//    outputs level and the four pulses; parameters DB_MS, LONG_MS, REPEAT_MS.
// TESTING (sim params: TICK_DIV=4, DB_MS=3, LONG_MS=10, REPEAT_MS=4)
//  1 sw[0] toggles every 2 ticks for 12 ticks -> no press_tick, db_level[0] stays 0.
//  2 sw[0] steady 1 -> press_tick[0] once, after 3rd tick seeing s=1; db_level[0]=1 same clk.
//  3 hold sw[0]=1, repeat_en=1 -> long_tick[0] 10 ticks after press, then repeat_tick[0]
//    every 4 ticks; repeat_en=0 -> no repeat_tick, db_level stays 1.
//  4 in HELD, sw[0]=0 for 2 ticks then 1 -> no release_tick; later 0 for 3 ticks ->
//    release_tick[0] once, db_level[0]=0.
//  5 sw[0] and sw[3] rise same clk -> press_tick=4'b1001 in one clk; other keys quiet.
//  6 rst_n low in LONG with sw[0]=1 -> all outputs 0 at once; after release press_tick[0]
//    after 3 ticks, long_tick only after 10 further ticks.

Source files
------------

// File: rtl/key_event_ctrl_pkg.sv
// Shared types and helpers for the multi-key debounce / event scheduler.
package key_event_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDebDn = 3'd1,
    StHeld  = 3'd2,
    StLong  = 3'd3,
    StDebUp = 3'd4
  } key_state_e;

  // One counter serves debounce, long-hold and repeat timing, so size it for the largest.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// Per-key debounce FSM: advances only on the shared sample tick and emits registered
// level plus single-cycle press/release/long/repeat pulses.
module key_event_fsm
  import key_event_ctrl_pkg::*;
#(
  parameter int unsigned DB_MS     = 20,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic smp_tick,
  input  logic s,
  input  logic repeat_en,
  output logic level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick
);

  localparam int unsigned CW = cnt_width(DB_MS, LONG_MS, REPEAT_MS);
  localparam logic [CW:0] DbCnt   = (CW + 1)'(DB_MS);
  localparam logic [CW:0] LongCnt = (CW + 1)'(LONG_MS);
  localparam logic [CW:0] RepCnt  = (CW + 1)'(REPEAT_MS);
  localparam logic [CW-1:0] CntOne = CW'(1);

  key_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic lng_q, lng_d;
  logic level_d, press_d, release_d, long_d, repeat_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lng_d     = lng_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    cnt_inc   = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    if (smp_tick) begin
      unique case (state_q)
        StIdle: begin
          if (s) begin
            if (DB_MS == 1) begin
              state_d = StHeld;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = StDebDn;
              cnt_d   = CntOne;
            end
          end
        end
        StDebDn: begin
          if (!s) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_inc == DbCnt) begin
            state_d = StHeld;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        StHeld, StLong: begin
          if (!s) begin
            // A single-sample debounce releases immediately instead of via StDebUp.
            if (DB_MS == 1) begin
              state_d   = StIdle;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              state_d = StDebUp;
              cnt_d   = CntOne;
              lng_d   = (state_q == StLong);
            end
          end else if (state_q == StHeld && cnt_inc == LongCnt) begin
            state_d = StLong;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else if (state_q == StLong && cnt_inc == RepCnt) begin
            cnt_d    = '0;
            repeat_d = repeat_en;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        StDebUp: begin
          if (s) begin
            state_d = lng_q ? StLong : StHeld;
            cnt_d   = '0;
          end else if (cnt_inc == DbCnt) begin
            state_d   = StIdle;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    level_d = (state_d == StHeld) || (state_d == StLong) || (state_d == StDebUp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lng_q        <= 1'b0;
      level        <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lng_q        <= lng_d;
      level        <= level_d;
      press_tick   <= press_d;
      release_tick <= release_d;
      long_tick    <= long_d;
      repeat_tick  <= repeat_d;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key debounce and event scheduler: per-bit synchronizers, one shared sample-tick
// prescaler and one key_event_fsm per key.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int unsigned NUM_KEYS  = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned DB_MS     = 20,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] sw,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] db_level,
  output logic [NUM_KEYS-1:0] press_tick,
  output logic [NUM_KEYS-1:0] release_tick,
  output logic [NUM_KEYS-1:0] long_tick,
  output logic [NUM_KEYS-1:0] repeat_tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PreOne = PW'(1);

  logic [PW-1:0]       pre_q;
  logic                smp_tick;
  logic [NUM_KEYS-1:0] sync1_q, sync2_q;

  assign smp_tick = (pre_q == PreMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      pre_q   <= smp_tick ? '0 : pre_q + PreOne;
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_event_fsm #(
      .DB_MS    (DB_MS),
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .smp_tick    (smp_tick),
      .s           (sync2_q[k]),
      .repeat_en   (repeat_en),
      .level       (db_level[k]),
      .press_tick  (press_tick[k]),
      .release_tick(release_tick[k]),
      .long_tick   (long_tick[k]),
      .repeat_tick (repeat_tick[k])
    );
  end

endmodule
